// File: rtl/tlc_pkg.sv
// Shared traffic-light-controller definitions: interval codes, parameter
// selector codes and default time values used by the timer and the FSM.
package tlc_pkg;

  typedef enum logic [2:0] {
    INT_BASE     = 3'b000,
    INT_EXT      = 3'b001,
    INT_YEL      = 3'b010,
    INT_2BASE    = 3'b011,
    INT_BASE_EXT = 3'b100
  } interval_e;

  typedef enum logic [1:0] {
    SEL_BASE     = 2'b00,
    SEL_EXT      = 2'b01,
    SEL_YEL      = 2'b10,
    SEL_DEFAULTS = 2'b11
  } sel_e;

  localparam logic [3:0] DEF_BASE_S = 4'd6;
  localparam logic [3:0] DEF_EXT_S  = 4'd3;
  localparam logic [3:0] DEF_YEL_S  = 4'd2;

  // Widest load is 2*15 = 30 seconds, which fits in 5 bits.
  localparam int LOAD_W = 5;

endpackage

// File: rtl/interval_timer_if.sv
// Control/status bundle between the traffic-light FSM (master) and the
// interval timer (slave).
interface interval_timer_if;
  logic       Prog_Sync;
  logic [1:0] Time_Parameter_Selector;
  logic [3:0] Time_Value;
  logic [2:0] interval;
  logic       start_timer;
  logic       expired;
  logic       one_hz_enable;

  modport master (
    output Prog_Sync, Time_Parameter_Selector, Time_Value, interval, start_timer,
    input  expired, one_hz_enable
  );

  modport slave (
    input  Prog_Sync, Time_Parameter_Selector, Time_Value, interval, start_timer,
    output expired, one_hz_enable
  );
endinterface

// File: rtl/one_hz_divider.sv
// Clock divider producing one tick per CYCLES_PER_SEC cycles while enabled.
// The count is parked at 0 when idle or cleared, so the first tick after a
// (re)start lands exactly CYCLES_PER_SEC cycles after the clear cycle.
module one_hz_divider #(
  parameter int CYCLES_PER_SEC = 100_000_000
) (
  input  logic clk,
  input  logic Reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CW = (CYCLES_PER_SEC > 1) ? $clog2(CYCLES_PER_SEC) : 1;
  localparam logic [CW-1:0] LAST = CW'(CYCLES_PER_SEC - 1);

  logic [CW-1:0] count;

  // Free-running count 0..LAST while enabled; held at 0 otherwise.
  always_ff @(posedge clk) begin
    if (Reset || clear || !enable) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  // A clear (restart) in the wrap cycle suppresses that tick.
  assign tick = enable && (count == LAST) && !clear && !Reset;

endmodule

// File: rtl/interval_timer.sv
// Programmable countdown timer for the traffic-light controller. Holds the
// base/extended/yellow times, loads the interval selected on start_timer,
// counts it down in seconds and pulses expired on the final second.
module interval_timer
  import tlc_pkg::*;
#(
  parameter int         CYCLES_PER_SEC = 100_000_000,
  parameter logic [3:0] DEF_BASE       = DEF_BASE_S,
  parameter logic [3:0] DEF_EXT        = DEF_EXT_S,
  parameter logic [3:0] DEF_YEL        = DEF_YEL_S
) (
  input logic             clk,
  input logic             Reset,
  interval_timer_if.slave bus
);

  // Times are never zero so a load can never expire on its own load cycle.
  function automatic logic [3:0] min_one(input logic [3:0] v);
    return (v == 4'd0) ? 4'd1 : v;
  endfunction

  logic [3:0]        t_base;
  logic [3:0]        t_ext;
  logic [3:0]        t_yel;
  logic [LOAD_W-1:0] load_value;
  logic [LOAD_W-1:0] remaining;
  logic              running;
  logic              tick;
  logic              final_tick;

  // Time parameter registers, written by the synchronised program strobe.
  always_ff @(posedge clk) begin
    if (Reset) begin
      t_base <= DEF_BASE;
      t_ext  <= DEF_EXT;
      t_yel  <= DEF_YEL;
    end else if (bus.Prog_Sync) begin
      case (bus.Time_Parameter_Selector)
        SEL_BASE: t_base <= min_one(bus.Time_Value);
        SEL_EXT:  t_ext  <= min_one(bus.Time_Value);
        SEL_YEL:  t_yel  <= min_one(bus.Time_Value);
        default: begin
          t_base <= DEF_BASE;
          t_ext  <= DEF_EXT;
          t_yel  <= DEF_YEL;
        end
      endcase
    end
  end

  // Interval mux; reads the registers as they stand, before any same-cycle write.
  always_comb begin
    load_value = {1'b0, t_base};
    case (bus.interval)
      INT_BASE:     load_value = {1'b0, t_base};
      INT_EXT:      load_value = {1'b0, t_ext};
      INT_YEL:      load_value = {1'b0, t_yel};
      INT_2BASE:    load_value = {t_base, 1'b0};
      INT_BASE_EXT: load_value = {1'b0, t_base} + {1'b0, t_ext};
      default:      load_value = {1'b0, t_base};
    endcase
  end

  one_hz_divider #(
    .CYCLES_PER_SEC(CYCLES_PER_SEC)
  ) u_div (
    .clk   (clk),
    .Reset (Reset),
    .clear (bus.start_timer),
    .enable(running),
    .tick  (tick)
  );

  // tick is already suppressed by a same-cycle restart, so restart wins here too.
  assign final_tick = tick && (remaining == LOAD_W'(1));

  // Countdown: load on start, decrement per second, stop at zero.
  always_ff @(posedge clk) begin
    if (Reset) begin
      remaining <= '0;
      running   <= 1'b0;
    end else if (bus.start_timer) begin
      remaining <= load_value;
      running   <= 1'b1;
    end else if (tick) begin
      remaining <= remaining - LOAD_W'(1);
      if (final_tick) begin
        running <= 1'b0;
      end
    end
  end

  assign bus.expired       = final_tick;
  assign bus.one_hz_enable = tick;

endmodule

// File: tb/tb_interval_timer.sv
// Scoreboard bench for interval_timer: stimulus pushes the cycles at which
// ticks and the expiry pulse are due; a monitor pops and compares them.
module tb_interval_timer;
  import tlc_pkg::*;

  localparam int C = 10;

  logic clk = 1'b0;
  logic Reset;
  interval_timer_if bus();

  interval_timer #(.CYCLES_PER_SEC(C)) dut (
    .clk  (clk),
    .Reset(Reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int passed = 0;
  int exp_q[$];
  int tick_q[$];
  int m_base = 6;
  int m_ext = 3;
  int m_yel = 2;

  function automatic int load_of(int code);
    case (code)
      1: return m_ext;
      2: return m_yel;
      3: return 2 * m_base;
      4: return m_base + m_ext;
      default: return m_base;
    endcase
  endfunction

  // One clock cycle of stimulus plus the reference model for that cycle.
  task automatic step(bit rst, bit prog, int sel, int val, bit start, int intv);
    int n;
    @(posedge clk);
    #1;
    Reset                       = rst;
    bus.Prog_Sync               = prog;
    bus.Time_Parameter_Selector = 2'(sel);
    bus.Time_Value              = 4'(val);
    bus.start_timer             = start;
    bus.interval                = 3'(intv);
    if (rst) begin
      exp_q.delete();
      tick_q.delete();
      m_base = 6; m_ext = 3; m_yel = 2;
    end else begin
      if (start) begin
        n = load_of(intv);
        exp_q.delete();
        tick_q.delete();
        for (int k = 1; k <= n; k++) tick_q.push_back(cyc + k * C);
        exp_q.push_back(cyc + n * C);
      end
      if (prog) begin
        case (sel)
          0: m_base = (val == 0) ? 1 : val;
          1: m_ext  = (val == 0) ? 1 : val;
          2: m_yel  = (val == 0) ? 1 : val;
          default: begin m_base = 6; m_ext = 3; m_yel = 2; end
        endcase
      end
    end
  endtask

  task automatic idle(int n);
    repeat (n) step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic check_quiet(string name);
    @(negedge clk);
    total++;
    if (bus.expired === 1'b0 && bus.one_hz_enable === 1'b0) passed++;
    else $display("FAIL %s: expired=%b one_hz_enable=%b, required 0/0", name, bus.expired, bus.one_hz_enable);
  endtask

  // Monitor: compare every observed pulse against the scoreboard queues.
  always @(negedge clk) begin
    int e;
    if (bus.expired === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        $display("FAIL expired_unexpected: pulse at cycle %0d, none due", cyc);
      end else begin
        e = exp_q.pop_front();
        if (e == cyc) passed++;
        else $display("FAIL expired_time: pulse at cycle %0d, due at %0d", cyc, e);
      end
    end else if (exp_q.size() > 0 && exp_q[0] <= cyc) begin
      total++;
      e = exp_q.pop_front();
      $display("FAIL expired_missing: no pulse at cycle %0d, due at %0d", cyc, e);
    end
    if (bus.one_hz_enable === 1'b1) begin
      total++;
      if (tick_q.size() == 0) begin
        $display("FAIL tick_unexpected: tick at cycle %0d, none due", cyc);
      end else begin
        e = tick_q.pop_front();
        if (e == cyc) passed++;
        else $display("FAIL tick_time: tick at cycle %0d, due at %0d", cyc, e);
      end
    end else if (tick_q.size() > 0 && tick_q[0] <= cyc) begin
      total++;
      e = tick_q.pop_front();
      $display("FAIL tick_missing: no tick at cycle %0d, due at %0d", cyc, e);
    end
  end

  initial begin
    bit r_rst, r_prog, r_start;
    Reset = 1'b1;
    bus.Prog_Sync = 1'b0;
    bus.Time_Parameter_Selector = 2'b00;
    bus.Time_Value = 4'd0;
    bus.start_timer = 1'b0;
    bus.interval = 3'b000;

    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    check_quiet("reset_outputs");

    // Default base interval: 6 s.
    step(0, 0, 0, 0, 1, 0); idle(70);

    // Yellow programmed to 5, then to 0 (stored as 1).
    step(0, 1, 2, 5, 0, 0);
    step(0, 0, 0, 0, 1, 2); idle(60);
    step(0, 1, 2, 0, 0, 0);
    step(0, 0, 0, 0, 1, 2); idle(20);

    // Large base/ext: 2*15 and 15+15.
    step(0, 1, 0, 15, 0, 0);
    step(0, 1, 1, 15, 0, 0);
    step(0, 0, 0, 0, 1, 3); idle(310);
    step(0, 0, 0, 0, 1, 4); idle(310);

    // Restore defaults, then restart mid-count with yellow.
    step(0, 1, 3, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0); idle(24);
    step(0, 0, 0, 0, 1, 2); idle(60);

    // Program in the same cycle as start: old value used, new one next time.
    step(0, 1, 0, 9, 1, 0); idle(70);
    step(0, 0, 0, 0, 1, 0); idle(100);

    // Restart in the exact cycle of the final tick.
    step(0, 1, 3, 0, 0, 0);
    step(0, 0, 0, 0, 1, 2); idle(19);
    step(0, 0, 0, 0, 1, 1); idle(40);

    // Reset mid-count, then defaults are back.
    step(0, 1, 0, 12, 0, 0);
    step(0, 0, 0, 0, 1, 0); idle(29);
    step(1, 0, 0, 0, 0, 0);
    check_quiet("reset_midcount");
    idle(70);
    step(0, 0, 0, 0, 1, 0); idle(65);
    step(0, 0, 0, 0, 1, 1); idle(35);
    step(0, 0, 0, 0, 1, 2); idle(25);

    // Program, restore with selector 11, then base+ext.
    step(0, 1, 0, 4, 0, 0);
    step(0, 1, 1, 7, 0, 0);
    step(0, 1, 3, 0, 0, 0);
    step(0, 0, 0, 0, 1, 4); idle(95);

    // Randomised traffic.
    for (int i = 0; i < 40; i++) begin
      r_rst   = ($urandom_range(0, 29) == 0);
      r_prog  = ($urandom_range(0, 9) < 3);
      r_start = ($urandom_range(0, 9) < 5);
      step(r_rst, r_prog, int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
           r_start, int'($urandom_range(0, 7)));
      idle(int'($urandom_range(0, 60)));
    end
    idle(320);

    total++;
    if (exp_q.size() == 0 && tick_q.size() == 0) passed++;
    else $display("FAIL drain: %0d expiries and %0d ticks still due, required 0/0", exp_q.size(), tick_q.size());

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
